// File: rtl/rfft_seq.sv
// ---------------------------------------------------------------------------
// rfft_seq : control sequencer for the 256-point radix-4 RFFT core.
//
// Owns the core's shared word address (2^ADDR_W words of 4 samples) and runs
// one frame as LOAD -> NSTAGE x (CALC + DRAIN) -> UNLOAD, then pulses done.
//
// Optional feature (compile-time macro RFFT_SEQ_BITREV_EN):
//   defined   : during UNLOAD, Addr is the base-4 digit reversal of the
//               transfer counter, so results leave in natural frequency order.
//   undefined : during UNLOAD, Addr equals the transfer counter.
//
// Ports
//   Clk        in   rising-edge clock
//   Reset_n    in   synchronous active-low reset
//   start      in   begin a frame (sampled in IDLE only)
//   abort      in   cancel the current frame, back to IDLE without done
//   in_valid   in   source has an input word
//   in_ready   out  sequencer accepts input words (LOAD)
//   out_valid  out  core output word presented (UNLOAD)
//   out_ready  in   sink takes the output word
//   Addr       out  core word address
//   Input      out  core input-buffer write strobe (in_valid & in_ready)
//   Write      out  core output-read phase enable
//   bf_en      out  issue one butterfly at Addr
//   stage      out  current butterfly stage
//   tw_base    out  twiddle exponent base of the current butterfly
//   busy       out  frame in progress
//   done       out  one-cycle pulse on frame completion
// ---------------------------------------------------------------------------
module rfft_seq #(
    parameter int ADDR_W   = 6,
    parameter int NSTAGE   = 4,
    parameter int PIPE_LAT = 3     // must be >= 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] Addr,
    output logic              Input,
    output logic              Write,
    output logic              bf_en,
    output logic [1:0]        stage,
    output logic [ADDR_W-1:0] tw_base,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0]  LAST_WORD  = {ADDR_W{1'b1}};
    localparam int                 DRAIN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);
    localparam logic [1:0]         STAGE_LAST = 2'(NSTAGE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_DRAIN,
        S_UNLOAD
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  cnt_q;
    logic [1:0]         stage_q;
    logic [DRAIN_W-1:0] drain_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               write_q;
    logic               bf_en_q;
    logic               busy_q;
    logic               done_q;

`ifdef RFFT_SEQ_BITREV_EN
    // Reverse the order of the 2-bit (base-4) digits of a word address.
    function automatic logic [ADDR_W-1:0] digit_rev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W / 2; i++) begin
            r[2*i +: 2] = a[ADDR_W-2-2*i +: 2];
        end
        return r;
    endfunction
`endif

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            stage_q     <= '0;
            drain_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            write_q     <= 1'b0;
            bf_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort && (state_q != S_IDLE)) begin
            // Abort beats any handshake in the same cycle: that word is dropped.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            stage_q     <= '0;
            drain_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            write_q     <= 1'b0;
            bf_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_LOAD;
                        cnt_q      <= '0;
                        stage_q    <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (cnt_q == LAST_WORD) begin
                            state_q    <= S_CALC;
                            cnt_q      <= '0;
                            stage_q    <= '0;
                            in_ready_q <= 1'b0;
                            bf_en_q    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    if (cnt_q == LAST_WORD) begin
                        // Counter parks at the last word until the stage is drained.
                        state_q <= S_DRAIN;
                        bf_en_q <= 1'b0;
                        drain_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        cnt_q <= '0;
                        if (stage_q == STAGE_LAST) begin
                            state_q     <= S_UNLOAD;
                            write_q     <= 1'b1;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_CALC;
                            stage_q <= stage_q + 1'b1;
                            bf_en_q <= 1'b1;
                        end
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                S_UNLOAD: begin
                    if (out_ready) begin
                        if (cnt_q == LAST_WORD) begin
                            state_q     <= S_IDLE;
                            cnt_q       <= '0;
                            stage_q     <= '0;
                            write_q     <= 1'b0;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Address mapping: only UNLOAD may remap the counter.
    always_comb begin
        Addr = cnt_q;
`ifdef RFFT_SEQ_BITREV_EN
        if (state_q == S_UNLOAD) begin
            Addr = digit_rev(cnt_q);
        end
`endif
    end

    // (Addr mod 4^(3-stage)) << 2*stage equals Addr << 2*stage truncated to
    // ADDR_W bits, so the shift alone drops the unwanted high digits.
    assign tw_base   = (state_q == S_CALC) ? (cnt_q << {stage_q, 1'b0}) : '0;

    assign Input     = in_valid & in_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Write     = write_q;
    assign bf_en     = bf_en_q;
    assign stage     = stage_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rfft_seq.sv
// ---------------------------------------------------------------------------
// tb_rfft_seq : directed self-checking bench for rfft_seq (default parameters).
// Expected UNLOAD addresses follow RFFT_SEQ_BITREV_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_rfft_seq;

    logic       Clk       = 1'b0;
    logic       Reset_n   = 1'b0;
    logic       start     = 1'b0;
    logic       abort     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [5:0] Addr;
    logic       Input;
    logic       Write;
    logic       bf_en;
    logic [1:0] stage;
    logic [5:0] tw_base;
    logic       busy;
    logic       done;

    rfft_seq dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Addr      (Addr),
        .Input     (Input),
        .Write     (Write),
        .bf_en     (bf_en),
        .stage     (stage),
        .tw_base   (tw_base),
        .busy      (busy),
        .done      (done)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // frame statistics
    int         k;
    int         n_input, n_bf, dup, tw_bad, tw21, unload_bad, unload_idx;
    int         load_cyc, stall_left, stall_bad, write_bad;
    int         done_k, busy_k0, rdy_k0;
    logic [7:0] stage_seq;
    logic [63:0] seen;
    logic [5:0] first_addr [0:5];
    bit         tog, stall_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] exp_unload(input int idx);
        logic [5:0] c;
        c = 6'(idx);
`ifdef RFFT_SEQ_BITREV_EN
        return {c[1:0], c[3:2], c[5:4]};
`else
        return c;
`endif
    endfunction

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    task automatic clear_stats();
        n_input = 0; n_bf = 0; dup = 0; tw_bad = 0; tw21 = -1; unload_bad = 0;
        unload_idx = 0; load_cyc = 0; stall_left = 5; stall_bad = 0; write_bad = 0;
        stage_seq = '0; seen = '0;
        for (int i = 0; i < 6; i++) first_addr[i] = '1;
    endtask

    // Inputs for the coming edge, chosen after sampling the current cycle.
    task automatic drive();
        in_valid = tog ? ((k % 2) == 0) : 1'b1;
        if (stall_en && out_valid && unload_idx == 10 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
            if (Addr !== exp_unload(10) || out_valid !== 1'b1) stall_bad++;
        end else begin
            out_ready = 1'b1;
        end
    endtask

    task automatic observe();
        if (in_ready) load_cyc++;
        if (Input) begin
            if (seen[Addr]) dup++;
            seen[Addr] = 1'b1;
            n_input++;
        end
        if (bf_en) begin
            n_bf++;
            if (Addr == 6'd0) stage_seq = {stage_seq[5:0], stage};
            if (stage == 2'd1 && Addr == 6'd21) tw21 = int'(tw_base);
            if (stage == 2'd3 && tw_base != 6'd0) tw_bad++;
            if (stage == 2'd0 && tw_base != Addr) tw_bad++;
        end
        if (out_valid !== Write) write_bad++;
        if (out_valid) begin
            if (Addr !== exp_unload(unload_idx)) unload_bad++;
            if (out_ready) begin
                if (unload_idx < 6) first_addr[unload_idx] = Addr;
                unload_idx++;
            end
        end
    endtask

    // Start a frame and run it until done (bounded). done_k is the number of
    // edges after the start edge at which done is seen.
    task automatic run_frame(input bit t, input bit s);
        clear_stats();
        tog = t;
        stall_en = s;
        start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        k = 0;
        busy_k0 = int'(busy);
        rdy_k0 = int'(in_ready);
        drive();
        #1;
        observe();
        while (done !== 1'b1 && k < 2000) begin
            @(posedge Clk);
            #1;
            k++;
            drive();
            #1;
            observe();
        end
        done_k = k;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},     32'(Addr), 0);
        check({tag, "_stage"},    32'(stage), 0);
        check({tag, "_tw"},       32'(tw_base), 0);
        check({tag, "_inrdy"},    32'(in_ready), 0);
        check({tag, "_ovalid"},   32'(out_valid), 0);
        check({tag, "_input"},    32'(Input), 0);
        check({tag, "_write"},    32'(Write), 0);
        check({tag, "_bfen"},     32'(bf_en), 0);
        check({tag, "_busy"},     32'(busy), 0);
        check({tag, "_done"},     32'(done), 0);
    endtask

    initial begin
        // ---- reset (in_valid high to prove Input stays low) ----
        in_valid = 1'b1;
        step();
        step();
        check_reset_outputs("rst");
        Reset_n = 1'b1;
        step();
        check("idle_busy", 32'(busy), 0);

        // ---- frame A: no stalls ----
        run_frame(1'b0, 1'b0);
        check("A_busy_k0", 32'(busy_k0), 1);
        check("A_rdy_k0", 32'(rdy_k0), 1);
        // done seen after edge N+396, i.e. in cycle N+397
        check("A_latency", 32'(done_k + 1), 397);
        check("A_inputs", 32'(n_input), 64);
        check("A_dup", 32'(dup), 0);
        check("A_bf", 32'(n_bf), 256);
        check("A_stages", 32'(stage_seq), 32'h1B);
        check("A_tw21", 32'(tw21), 20);
        check("A_twbad", 32'(tw_bad), 0);
        check("A_unload_n", 32'(unload_idx), 64);
        check("A_unload_addr", 32'(unload_bad), 0);
        check("A_write", 32'(write_bad), 0);
        check("A_busy_at_done", 32'(busy), 0);
`ifdef RFFT_SEQ_BITREV_EN
        check("A_ua1", 32'(first_addr[1]), 16);
        check("A_ua4", 32'(first_addr[4]), 4);
        check("A_ua5", 32'(first_addr[5]), 20);
`else
        check("A_ua1", 32'(first_addr[1]), 1);
        check("A_ua4", 32'(first_addr[4]), 4);
        check("A_ua5", 32'(first_addr[5]), 5);
`endif
        step();
        check("A_done_1cyc", 32'(done), 0);

        // ---- frame B: toggled in_valid, 5-cycle out_ready stall at 10 ----
        run_frame(1'b1, 1'b1);
        check("B_load_cyc", 32'(load_cyc), 127);
        check("B_inputs", 32'(n_input), 64);
        check("B_dup", 32'(dup), 0);
        check("B_stall_used", 32'(stall_left), 0);
        check("B_stall_hold", 32'(stall_bad), 0);
        check("B_unload_addr", 32'(unload_bad), 0);
        check("B_latency", 32'(done_k + 1), 397 + 63 + 5);
        step();

        // ---- frame C: abort at LOAD word 30 ----
        in_valid = 1'b1;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 30; i++) step();
        check("C_addr30", 32'(Addr), 30);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("C_busy", 32'(busy), 0);
        check("C_inrdy", 32'(in_ready), 0);
        check("C_addr", 32'(Addr), 0);
        check("C_done", 32'(done), 0);
        step();
        check("C_done2", 32'(done), 0);

        // ---- frame D: start ignored mid-CALC, reset during UNLOAD ----
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 74; i++) step();
        check("D_calc_bf", 32'(bf_en), 1);
        check("D_calc_addr", 32'(Addr), 10);
        start = 1'b1;
        step();
        start = 1'b0;
        check("D_ign_addr", 32'(Addr), 11);
        check("D_ign_stage", 32'(stage), 0);
        check("D_ign_bf", 32'(bf_en), 1);
        for (int i = 0; i < 400 && out_valid !== 1'b1; i++) step();
        check("D_reach_unload", 32'(out_valid), 1);
        for (int i = 0; i < 20; i++) step();
        check("D_unload_addr", 32'(Addr), 32'(exp_unload(20)));
        Reset_n = 1'b0;
        step();
        check_reset_outputs("D_rst");
        Reset_n = 1'b1;
        step();
        check("D_idle_after", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rfft_seq.md
# rfft_seq

Sequencer for the 256-point radix-4 RFFT core. It owns the core's shared 6-bit word address (64 words × 4 samples) and runs a job in three phases: input load, four butterfly stages, output unload. It sits between the sample source/sink handshakes and the `rfft` datapath and drives that core's `Addr`, `Input` and `Write` controls, plus the butterfly enables.

## Interface
Parameters:
- `ADDR_W`, 6: word address width; 2^ADDR_W words per frame.
- `NSTAGE`, 4: radix-4 butterfly stages per frame.
- `PIPE_LAT`, 3: butterfly pipeline drain cycles inserted after each stage.

Ports:
- `Clk` in 1: clock, rising edge.
- `Reset_n` in 1: reset. One clock; reset is synchronous and active-low.
- `start` in 1: begin a frame; sampled only in IDLE.
- `abort` in 1: cancel the frame; return to IDLE; no `done`.
- `in_valid` in 1, `in_ready` out 1: handshake for input words.
- `out_valid` out 1, `out_ready` in 1: handshake for output words.
- `Addr` out ADDR_W: core word address.
- `Input` out 1: core input-buffer write strobe.
- `Write` out 1: core output-read phase enable.
- `bf_en` out 1: issue one butterfly at `Addr`.
- `stage` out 2: current stage, 0..NSTAGE-1.
- `tw_base` out ADDR_W: twiddle exponent base for the current butterfly.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a frame completes.

## Operation
- States: IDLE, LOAD, CALC, DRAIN, UNLOAD.
- IDLE: when `start`=1, go to LOAD and clear the address counter.
- LOAD:
  - `in_ready`=1. `Input` = `in_valid & in_ready`, combinational.
  - `Addr` advances by 1 on each accepted word.
  - After word 63 is accepted, go to CALC with `stage`=0 and `Addr`=0.
- CALC:
  - `bf_en`=1 every cycle and `Addr` counts 0..63.
  - `tw_base` = (`Addr` mod 4^(3-stage)) << (2·stage), truncated to ADDR_W.
  - After `Addr`=63, go to DRAIN.
- DRAIN:
  - `bf_en`=0 for PIPE_LAT cycles.
  - If `stage` < NSTAGE-1: increment `stage`, set `Addr`=0, go to CALC.
  - Otherwise go to UNLOAD with the counter at 0.
- UNLOAD:
  - `Write`=1 and `out_valid`=1. The core's `Dout0..3` are valid in the same cycle for `Addr`.
  - The counter advances on `out_valid & out_ready`. `Addr` is the counter mapped per Configuration.
  - After transfer 63, pulse `done` and go to IDLE.
- Counter wraps 63→0 only on a phase transition; it never wraps inside a phase.
- `abort` (any state except IDLE): next state IDLE, counter cleared, `done` stays low.
- `in_valid` outside LOAD and `out_ready` outside UNLOAD are ignored.

## Timing
- Reset values: IDLE; `Addr`=0, `stage`=0, `tw_base`=0; `in_ready`, `out_valid`, `Input`, `Write`, `bf_en`, `busy`, `done` all 0.
- Reset wins over `start`/`abort`. A reset mid-frame takes effect at the next edge, with all outputs at reset values.
- `start` is accepted at edge N: `busy`=1 and `in_ready`=1 from cycle N+1.
- Minimum frame (no stalls): 1 + 64 + 4·(64+PIPE_LAT) + 64 cycles from `start` to `done`; 397 with default parameters.
- `done` is asserted in the cycle after the last output handshake and lasts exactly one cycle. `busy` falls in that same cycle.
- `start` while `busy` is ignored.
- `abort` has priority over a simultaneous handshake; that word is not counted.
- `in_valid` low stalls LOAD indefinitely; `Input` stays 0 during the stall.
- `out_ready` low holds `Addr` and `out_valid` stable.

## Configuration
- `RFFT_SEQ_BITREV_EN` defined: UNLOAD `Addr` = base-4 digit reversal of the counter (the three 2-bit digits swapped: d2d1d0 → d0d1d2), so output emerges in natural frequency order.
- `RFFT_SEQ_BITREV_EN` undefined: UNLOAD `Addr` = counter (natural memory order). No other behaviour changes.

## Test plan
- Reset, then one cycle `start`, in_valid always 1, out_ready always 1, defaults → `done` exactly 397 cycles after the start edge; 64 `Input` pulses; 256 `bf_en` cycles; `stage` steps 0,1,2,3.
- During CALC with `stage`=1 and `Addr`=21 → `tw_base`=20 ((21 mod 16)<<2). With `stage`=3 → `tw_base`=0 for every `Addr`.
- LOAD with `in_valid` toggled 1,0,1,0… → `Addr` advances only on accepted words; LOAD lasts 127 cycles; no duplicate `Input` pulse at any address.
- UNLOAD with `out_ready` low for 5 cycles at counter 10 → `Addr` held at 10 (or 40 with BITREV) and `out_valid`=1 throughout; `done` delayed by 5 cycles.
- `abort` at LOAD word 30; `start` pulsed mid-CALC; `Reset_n`=0 during UNLOAD → first: IDLE next cycle with no `done`; second: ignored; third: every output at its reset value after the edge.
- `RFFT_SEQ_BITREV_EN` defined → UNLOAD `Addr` sequence begins 0,16,32,48,4,20…
